fetch_unit: RTL and testbench

Instruction fetch front end for the riscy_core pipeline. It supplies the control decoder with the instruction fields it consumes (op, funct3, funct7), and it consumes the decoder's PCSrc output together with the branch/jump target to redirect the program counter. It owns the PC register, issues in-order requests to instruction memory, and buffers returned words in a small FIFO for the decode stage.

---
 rtl/fetch_unit.sv | 157 +++++++++++++++
 tb/tb_fetch_unit.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, issues in-order imem requests and
// buffers returned words for decode. Optional misalign trap: FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
    parameter int unsigned    XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int unsigned    FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus4,
    output logic [6:0]      op,
    output logic [2:0]      funct3,
    output logic            funct7,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic            fetch_fault,
`endif
    input  logic            PCSrc,
    input  logic [XLEN-1:0] PCTarget
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     word;
    } entry_t;

    entry_t          buf_q [FIFO_DEPTH];
    entry_t          head;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic            active_q;
    logic            fault_q, fault_d;
    logic            misalign;
    logic            blocked;
    logic [XLEN-1:0] target;
    logic            rsp;
    logic            push;
    logic            pop;

    // Redirect target handling: trap on misalignment or silently align
    always_comb begin
        target   = PCTarget;
        misalign = 1'b0;
        blocked  = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        misalign = (PCTarget[1:0] != 2'b00);
        blocked  = fault_q;
`else
        target[1:0] = 2'b00;
`endif
    end

    assign imem_req = active_q && !PCSrc && !blocked
                      && ((count_q + outst_q) < CW'(FIFO_DEPTH));
    assign imem_addr   = fetch_pc_q;
    assign rsp         = imem_rvalid && (outst_q != '0);
    assign instr_valid = (count_q != '0);
    assign pop         = instr_valid && instr_ready;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        discard_d  = discard_q;
        fault_d    = fault_q;
        push       = 1'b0;
        outst_d    = outst_q + CW'(imem_req) - CW'(rsp);
        if (PCSrc) begin
            // Everything in flight now belongs to the abandoned stream
            fetch_pc_d = target;
            resp_pc_d  = target;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            discard_d  = outst_q - CW'(rsp);
            fault_d    = misalign;
        end else begin
            if (imem_req) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (rsp) begin
                if (discard_q != '0) begin
                    discard_d = discard_q - CW'(1);
                end else begin
                    push      = 1'b1;
                    wr_ptr_d  = wr_ptr_q + PW'(1);
                    resp_pc_d = resp_pc_q + XLEN'(4);
                end
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            outst_q    <= '0;
            discard_q  <= '0;
            active_q   <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            active_q   <= 1'b1;
            fault_q    <= fault_d;
        end
    end

    // Payload storage needs no reset; reads are masked by instr_valid
    always_ff @(posedge clk) begin
        if (push) begin
            buf_q[wr_ptr_q] <= '{pc: resp_pc_q, word: imem_rdata};
        end
    end

    assign head     = buf_q[rd_ptr_q];
    assign instr    = instr_valid ? head.word : 32'h0;
    assign pc_out   = instr_valid ? head.pc : resp_pc_q;
    assign pc_plus4 = pc_out + XLEN'(4);
    assign op       = instr[6:0];
    assign funct3   = instr[14:12];
    assign funct7   = instr[30];

`ifdef FETCH_MISALIGN_TRAP_EN
    assign fetch_fault = fault_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model with random latency and a
// program-order reference of expected fetch and delivery addresses.
module tb_fetch_unit;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7;
    logic        PCSrc = 1'b0;
    logic [31:0] PCTarget = 32'h0;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fetch_fault;
`endif

    always #5 clk = ~clk;

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .pc_out(pc_out), .pc_plus4(pc_plus4),
        .op(op), .funct3(funct3), .funct7(funct7),
`ifdef FETCH_MISALIGN_TRAP_EN
        .fetch_fault(fetch_fault),
`endif
        .PCSrc(PCSrc), .PCTarget(PCTarget)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mem_q[$];
    logic [31:0] req_log[$];
    logic [31:0] pop_log[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          n_req = 0;
    int          first_req_cyc = -1;
    int          first_valid_cyc = -1;
    logic [31:0] exp_fetch = 32'h0;
    logic [31:0] exp_deliver = 32'h0;
    bit          fault_m = 1'b0;

    logic        s_req, s_valid, s_f7, s_fault;
    logic [31:0] s_addr, s_instr, s_pc, s_pc4;
    logic [6:0]  s_op, fv_op;
    logic [2:0]  s_f3, fv_f3;
    logic        fv_f7;
    logic [31:0] fv_pc4;

    // Memory contents: address 0 holds lw x1,0(x0)
    function automatic logic [31:0] word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_2083;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic sample();
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_valid = instr_valid;
        s_instr = instr;
        s_pc    = pc_out;
        s_pc4   = pc_plus4;
        s_op    = op;
        s_f3    = funct3;
        s_f7    = funct7;
`ifdef FETCH_MISALIGN_TRAP_EN
        s_fault = fetch_fault;
`else
        s_fault = 1'b0;
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        PCSrc       = 1'b0;
        instr_ready = 1'b0;
        imem_rvalid = 1'b0;
        #1;
        sample();
        check("rst_req", 32'(s_req), 32'h0);
        check("rst_valid", 32'(s_valid), 32'h0);
        check("rst_instr", s_instr, 32'h0);
        check("rst_pc_out", s_pc, 32'h0);
        check("rst_fields", {22'h0, s_f7, s_f3, s_op}, 32'h0);
        check("rst_fault", 32'(s_fault), 32'h0);
        repeat (2) @(negedge clk);
        mem_q.delete();
        req_log.delete();
        pop_log.delete();
        exp_fetch       = 32'h0;
        exp_deliver     = 32'h0;
        fault_m         = 1'b0;
        cyc             = 0;
        first_req_cyc   = -1;
        first_valid_cyc = -1;
        rst_n           = 1'b1;
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model
    task automatic run_cycle(input bit redir, input logic [31:0] tgt, input bit rdy,
                             input int lat_lo, input int lat_hi);
        bit          rsp;
        logic [31:0] ew;
        @(negedge clk);
        rsp         = (mem_q.size() != 0) && (mem_q[0].due <= cyc);
        imem_rvalid = rsp;
        imem_rdata  = rsp ? word(mem_q[0].addr) : 32'($urandom);
        PCSrc       = redir;
        PCTarget    = tgt;
        instr_ready = rdy;
        #1;
        sample();
        if (redir) check("req_in_redirect", 32'(s_req), 32'h0);
        if (fault_m) begin
            check("req_while_fault", 32'(s_req), 32'h0);
            check("valid_while_fault", 32'(s_valid), 32'h0);
        end
        if (s_req) begin
            check("imem_addr", s_addr, exp_fetch);
            check("occupancy", 32'(mem_q.size() < DEPTH), 32'h1);
        end
        if (s_valid) begin
            ew = word(exp_deliver);
            check("pc_out", s_pc, exp_deliver);
            check("instr", s_instr, ew);
            check("op", 32'(s_op), 32'(ew[6:0]));
            check("funct3", 32'(s_f3), 32'(ew[14:12]));
            check("funct7", 32'(s_f7), 32'(ew[30]));
            check("pc_plus4", s_pc4, exp_deliver + 32'd4);
        end else begin
            check("instr_empty", s_instr, 32'h0);
            check("fields_empty", {22'h0, s_f7, s_f3, s_op}, 32'h0);
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        check("fetch_fault", 32'(s_fault), 32'(fault_m));
`endif
        if (s_req) begin
            if (first_req_cyc < 0) first_req_cyc = cyc;
            req_log.push_back(s_addr);
            n_req++;
        end
        if (s_valid && first_valid_cyc < 0) begin
            first_valid_cyc = cyc;
            fv_op  = s_op;
            fv_f3  = s_f3;
            fv_f7  = s_f7;
            fv_pc4 = s_pc4;
        end
        if (rsp) void'(mem_q.pop_front());
        if (s_req) mem_q.push_back('{s_addr, cyc + int'($urandom_range(lat_hi, lat_lo))});
        if (redir) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_m     = (tgt[1:0] != 2'b00);
            exp_fetch   = tgt;
            exp_deliver = tgt;
`else
            exp_fetch   = {tgt[31:2], 2'b00};
            exp_deliver = {tgt[31:2], 2'b00};
`endif
        end else begin
            if (s_req) exp_fetch = exp_fetch + 32'd4;
            if (s_valid && rdy) begin
                pop_log.push_back(s_pc);
                exp_deliver = exp_deliver + 32'd4;
            end
        end
        cyc++;
    endtask

    initial begin
        int          n0;
        int          pops;
        bit          found;
        logic [31:0] tgt;

        do_reset();

        // Reset release with a 1-cycle memory and decode always ready
        repeat (8) run_cycle(1'b0, 32'h0, 1'b1, 1, 1);
        check("seq_addr0", req_log[0], 32'h0);
        check("seq_addr1", req_log[1], 32'h4);
        check("seq_addr2", req_log[2], 32'h8);
        check("first_valid_lat", 32'(first_valid_cyc - first_req_cyc), 32'd2);
        check("seq_pc0", pop_log[0], 32'h0);
        check("seq_pc1", pop_log[1], 32'h4);
        check("seq_pc2", pop_log[2], 32'h8);
        check("lw_op", 32'(fv_op), 32'h03);
        check("lw_funct3", 32'(fv_f3), 32'h2);
        check("lw_funct7", 32'(fv_f7), 32'h0);
        check("lw_pc_plus4", fv_pc4, 32'h4);

        // Decode stalled: only FIFO_DEPTH requests go out, resume after first pop
        run_cycle(1'b1, 32'h40, 1'b0, 1, 1);
        n0 = n_req;
        repeat (5) run_cycle(1'b0, 32'h0, 1'b0, 1, 1);
        check("stall_reqs", 32'(n_req - n0), 32'(DEPTH));
        check("stall_req_low", 32'(s_req), 32'h0);
        run_cycle(1'b0, 32'h0, 1'b1, 1, 1);
        check("stall_pop_valid", 32'(s_valid), 32'h1);
        run_cycle(1'b0, 32'h0, 1'b1, 1, 1);
        check("stall_req_resume", 32'(s_req), 32'h1);

        // 3-cycle memory, redirect with two requests outstanding
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (mem_q.size() == DEPTH) begin
                run_cycle(1'b1, 32'h100, 1'b1, 3, 3);
                found = 1'b1;
            end else begin
                run_cycle(1'b0, 32'h0, 1'b1, 3, 3);
            end
        end
        check("lat3_two_outstanding", 32'(found), 32'h1);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            run_cycle(1'b0, 32'h0, 1'b1, 3, 3);
            found = s_valid;
        end
        check("lat3_valid_seen", 32'(found), 32'h1);
        check("lat3_pc_after_redirect", s_pc, 32'h100);

        // Redirect coinciding with a response and a pop
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (instr_valid && mem_q.size() != 0 && mem_q[0].due <= cyc) begin
                run_cycle(1'b1, 32'h300, 1'b1, 1, 1);
                found = 1'b1;
            end else begin
                run_cycle(1'b0, 32'h0, 1'b1, 1, 1);
            end
        end
        check("coincide_found", 32'(found), 32'h1);
        run_cycle(1'b0, 32'h0, 1'b1, 1, 1);
        check("coincide_flushed", 32'(s_valid), 32'h0);
        repeat (6) run_cycle(1'b0, 32'h0, 1'b1, 1, 1);

        // Misaligned redirect target
`ifdef FETCH_MISALIGN_TRAP_EN
        run_cycle(1'b1, 32'h102, 1'b1, 1, 1);
        run_cycle(1'b0, 32'h0, 1'b1, 1, 1);
        check("fault_set", 32'(s_fault), 32'h1);
        check("fault_req_blocked", 32'(s_req), 32'h0);
        repeat (3) run_cycle(1'b0, 32'h0, 1'b1, 1, 1);
        run_cycle(1'b1, 32'h200, 1'b1, 1, 1);
        run_cycle(1'b0, 32'h0, 1'b1, 1, 1);
        check("fault_cleared", 32'(s_fault), 32'h0);
        check("fault_clear_req", 32'(s_req), 32'h1);
        check("fault_clear_addr", s_addr, 32'h200);
`else
        run_cycle(1'b1, 32'h102, 1'b1, 1, 1);
        run_cycle(1'b0, 32'h0, 1'b1, 1, 1);
        check("align_req", 32'(s_req), 32'h1);
        check("align_addr", s_addr, 32'h100);
`endif
        repeat (4) run_cycle(1'b0, 32'h0, 1'b1, 1, 1);

        // Address wrap past the top of memory
        run_cycle(1'b1, 32'hFFFF_FFF8, 1'b1, 1, 1);
        req_log.delete();
        pop_log.delete();
        repeat (10) run_cycle(1'b0, 32'h0, 1'b1, 1, 1);
        check("wrap_req", req_log[2], 32'h0);
        check("wrap_pop", pop_log[2], 32'h0);

        // Random traffic
        pops = pop_log.size();
        for (int i = 0; i < 2000; i++) begin
            tgt = $urandom;
            tgt[1:0] = 2'b00;
            if ($urandom_range(7, 0) == 0) tgt[31:8] = 24'hFFFF_FF;
            run_cycle($urandom_range(15, 0) == 0, tgt, $urandom_range(9, 0) < 7, 1, 4);
        end
        check("random_progress", 32'(pop_log.size() - pops > 100), 32'h1);

        // Reset in the middle of traffic
        do_reset();
        repeat (4) run_cycle(1'b0, 32'h0, 1'b1, 1, 1);
        check("post_reset_addr", req_log[0], 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
